// File: rtl/d_f_f.sv
// -----------------------------------------------------------------------------
// d_f_f : WIDTH-bit D flip-flop with registered true and complement outputs.
//
// Every bit is an independent cell (d_f_f_bit) holding two flops: one loads
// d_in[i] and the other loads ~d_in[i]. Each output comes straight from its own
// flop. Because both flops are written on the same edge, and are both forced
// during reset, qb_tog is always the inverse of q_out. There is no
// combinational path from d_in to either output.
//
// Ports
//   clk    : in  1     rising-edge clock
//   rs     : in  1     asynchronous active-high reset
//   d_in   : in  WIDTH data to capture
//   q_out  : out WIDTH registered d_in        (RST_VAL while rs=1)
//   qb_tog : out WIDTH registered ~d_in       (~RST_VAL while rs=1)
//
// Parameters
//   WIDTH   : 1..64 data bits
//   RST_VAL : value q_out takes during reset
// -----------------------------------------------------------------------------

// Single-bit cell: a true flop and a complement flop.
module d_f_f_bit #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rs,
   input  logic d,
   output logic q,
   output logic qb
);

   // Store ~d instead of deriving qb from q. This keeps qb flop-driven.
   // It also lets an X on d reach both outputs as X.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         q  <= RST_BIT;
         qb <= ~RST_BIT;
      end else begin
         q  <= d;
         qb <= ~d;
      end
   end

endmodule

module d_f_f #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rs,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] qb_tog
);

   // One cell per bit. A bit's outputs depend only on that bit's input.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_f_f_bit #(
         .RST_BIT (RST_VAL[i])
      ) u_bit (
         .clk (clk),
         .rs  (rs),
         .d   (d_in[i]),
         .q   (q_out[i]),
         .qb  (qb_tog[i])
      );
   end

endmodule

// File: tb/tb_d_f_f.sv
// -----------------------------------------------------------------------------
// tb_d_f_f : directed bench for d_f_f.
// The bench drives two instances from a shared clock and reset:
//   u1 : default parameters (WIDTH=1, RST_VAL=0)
//   u8 : WIDTH=8, RST_VAL=8'hA5
// The clock period is 4 and the clock starts high, so rising edges fall on
// t = 4, 8, 12, ...
// -----------------------------------------------------------------------------
module tb_d_f_f;

   logic       clk;
   logic       rs;
   logic       d1;
   logic       q1, qb1;
   logic [7:0] d8, q8, qb8;

   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 1'b0;

   d_f_f u1 (
      .clk    (clk),
      .rs     (rs),
      .d_in   (d1),
      .q_out  (q1),
      .qb_tog (qb1)
   );

   d_f_f #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
      .clk    (clk),
      .rs     (rs),
      .d_in   (d8),
      .q_out  (q8),
      .qb_tog (qb8)
   );

   initial begin
      clk = 1'b1;
      forever #2 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Complement invariant, checked on every falling edge once out of reset.
   always @(negedge clk) begin
      if (armed && rs === 1'b0) begin
         check("inv_w1", {7'd0, qb1}, {7'd0, ~q1});
         check("inv_w8", qb8, ~q8);
      end
   end

   logic [7:0] pats [3];
   logic [7:0] xv;
   logic [3:0] tog;
   logic       prev;

   initial begin
      pats = '{8'h81, 8'h5A, 8'h00};
      tog  = 4'b0101;            // bit i is the value driven in step i: 1,0,1,0

      // Reset asserted at t=0 with d_in=1 / 3C.
      rs = 1'b1; d1 = 1'b1; d8 = 8'h3C;
      #1;
      check("rst_q1",  {7'd0, q1},  8'h00);
      check("rst_qb1", {7'd0, qb1}, 8'h01);
      check("rst_q8",  q8,  8'hA5);
      check("rst_qb8", qb8, 8'h5A);
      #4;                         // t=5: a rising edge has passed, reset still holds
      check("rst_edge_q1", {7'd0, q1}, 8'h00);
      check("rst_edge_q8", q8, 8'hA5);
      #1 rs = 1'b0;               // t=6: release between edges
      #1;                         // t=7: no capture yet
      check("rel_hold_q1",  {7'd0, q1},  8'h00);
      check("rel_hold_qb1", {7'd0, qb1}, 8'h01);
      armed = 1'b1;

      // First capture at t=8.
      @(posedge clk); #1;
      check("cap_q1",  {7'd0, q1},  8'h01);
      check("cap_qb1", {7'd0, qb1}, 8'h00);
      check("cap_q8",  q8,  8'h3C);
      check("cap_qb8", qb8, 8'hC3);
      d8 = 8'hFF;
      @(posedge clk); #1;
      check("ff_q8",  q8,  8'hFF);
      check("ff_qb8", qb8, 8'h00);

      // Held input: the outputs must not move up to t=400.
      repeat (97) begin
         @(posedge clk); #1;
         check("stable_q1", {7'd0, q1}, 8'h01);
      end

      // Per-bit independence on the wide instance.
      for (int i = 0; i < 3; i++) begin
         d8 = pats[i];
         @(posedge clk); #1;
         check("pat_q8",  q8,  pats[i]);
         check("pat_qb8", qb8, ~pats[i]);
      end

      // Unknown on one bit propagates to that bit of both outputs.
      xv = 8'h00;
      xv[0] = 1'bx;
      d8 = xv;
      @(posedge clk); #1;
      check("x_q8",  q8,  xv);
      check("x_qb8", qb8, ~xv);
      d8 = 8'h00;

      // Toggle 1,0,1,0 just after successive edges. Each value should show up
      // one edge later, and a falling edge must not move the outputs.
      prev = q1;
      d1 = tog[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("neg_hold_q1", {7'd0, q1}, {7'd0, prev});
         @(posedge clk); #1;
         check("tog_q1",  {7'd0, q1},  {7'd0, tog[i]});
         check("tog_qb1", {7'd0, qb1}, {7'd0, ~tog[i]});
         prev = tog[i];
         if (i < 3) d1 = tog[i+1];
      end

      // Reset asserted between edges takes effect before the next edge.
      d1 = 1'b1; d8 = 8'h3C;
      @(posedge clk); #1;
      check("pre_rst_q1", {7'd0, q1}, 8'h01);
      rs = 1'b1;
      #1;
      check("async_q1",  {7'd0, q1},  8'h00);
      check("async_qb1", {7'd0, qb1}, 8'h01);
      check("async_q8",  q8,  8'hA5);
      check("async_qb8", qb8, 8'h5A);
      @(posedge clk); #1;
      check("rst_hold_q1", {7'd0, q1}, 8'h00);

      // Release exactly on a rising edge. The nonblocking update lands after
      // the flop has seen rs=1, so this edge still belongs to reset.
      @(posedge clk);
      rs <= 1'b0;
      #1;
      check("edge_rel_q1",  {7'd0, q1},  8'h00);
      check("edge_rel_qb1", {7'd0, qb1}, 8'h01);
      check("edge_rel_q8",  q8, 8'hA5);
      @(posedge clk); #1;
      check("post_rel_q1",  {7'd0, q1},  8'h01);
      check("post_rel_qb1", {7'd0, qb1}, 8'h00);
      check("post_rel_q8",  q8,  8'h3C);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/d_f_f.md
D_F_F -- requirements
Module: d_f_f

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits; legal range 1 to 64.
REQ-002 Parameter RST_VAL, default all-zeros, WIDTH-bit value that q_out takes during reset.
REQ-003 Clocking: one clock; reset is asynchronous and active-high. Clock port is clk and reset port is rs.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rs: input, 1 bit, asynchronous active-high reset.
REQ-006 Port d_in: input, WIDTH bits, data to capture.
REQ-007 Port q_out: output, WIDTH bits, registered true output.
REQ-008 Port qb_tog: output, WIDTH bits, registered complement output.
REQ-009 The block SHALL contain no other ports, and both outputs SHALL be driven directly by flops.

Function
REQ-010 On each clk rising edge with rs=0, q_out SHALL load d_in, and qb_tog SHALL load the bitwise inverse of d_in.
REQ-011 Latency SHALL be exactly one clk rising edge from d_in to q_out/qb_tog, with no combinational path from d_in to either output.
REQ-012 Outputs SHALL hold their value between rising edges; falling edges of clk SHALL have no effect.
REQ-013 At every instant outside reset, qb_tog SHALL equal the bitwise inverse of q_out, including the cycle after reset release.
REQ-014 Each bit position SHALL be independent: bit i of q_out depends only on bit i of d_in.
REQ-015 With d_in held constant, outputs SHALL stay constant from the first post-reset capture onward: no toggling and no glitches.
REQ-016 An unknown value (X/Z) on a d_in bit at a rising edge SHALL propagate as unknown to that bit of both outputs.
REQ-017 The block SHALL hold no other state, no enable and no counter.

Reset
REQ-018 While rs=1, q_out SHALL equal RST_VAL and qb_tog SHALL equal ~RST_VAL, regardless of clk and d_in.
REQ-019 The reset response SHALL occur immediately on rs rising, without waiting for a clk edge.
REQ-020 If rs is 1 at a clk rising edge, reset SHALL win and d_in SHALL be ignored at that edge.
REQ-021 After rs falls, the first capture SHALL occur at the first clk rising edge at which rs=0.
REQ-022 Asserting rs mid-operation SHALL override the held data at once; the outputs SHALL stay at reset values until the rule in REQ-021 applies.
REQ-023 Power-up values before the first reset or the first capture are undefined and SHALL NOT be relied upon.

Verification
REQ-024 Defaults (WIDTH=1), clk period 4 time units, d_in=1, rs pulsed high for 6 units and then low -> during reset q_out=0, qb_tog=1; from the first rising edge after release q_out=1, qb_tog=0, stable until 400 units.
REQ-025 rs=0, d_in toggled 1,0,1,0 just after successive rising edges -> q_out follows one edge later with 1,0,1,0, and qb_tog shows 0,1,0,1.
REQ-026 q_out=1, then rs asserted between clock edges -> q_out=0 and qb_tog=1 within the same time step, before the next rising edge.
REQ-027 rs deasserted exactly at a rising edge with d_in=1 -> outputs stay 0/1 at that edge and become 1/0 at the following edge.
REQ-028 WIDTH=8, RST_VAL=8'hA5, d_in sequence 8'h3C then 8'hFF -> in reset q_out=A5, qb_tog=5A; then q_out=3C, qb_tog=C3; then q_out=FF, qb_tog=00.
REQ-029 Every scenario SHALL include a continuous check that qb_tog == ~q_out whenever rs=0.
